// File: rtl/can_tx_pkg.sv
// Shared types for the CAN transmit scheduler.
// Frame bundle, scheduler states and source encodings.
package can_tx_pkg;

    typedef struct packed {
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        logic        frame_type;
    } can_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_ACTIVE
    } sched_state_t;

    localparam logic SRC_FIFO = 1'b0;
    localparam logic SRC_RETX = 1'b1;

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Host-side frame handshake into the transmit scheduler.
// master = host, slave = scheduler.
interface can_tx_scheduler_if;

    logic        host_valid;
    logic        host_ready;
    logic [10:0] host_identifier;
    logic [3:0]  host_dlc;
    logic [63:0] host_data;
    logic        host_frame_type;

    modport master (
        output host_valid,
        output host_identifier,
        output host_dlc,
        output host_data,
        output host_frame_type,
        input  host_ready
    );

    modport slave (
        input  host_valid,
        input  host_identifier,
        input  host_dlc,
        input  host_data,
        input  host_frame_type,
        output host_ready
    );

endinterface

// File: rtl/tx_frame_fifo.sv
// Circular frame buffer for host frames awaiting launch.
// Push while full is dropped; clear empties it synchronously.
module tx_frame_fifo
    import can_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  can_frame_t             push_frame,
    input  logic                   pop,
    output can_frame_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    can_frame_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push && !clear)
            mem[wr_ptr] <= push_frame;
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Arbitrates retransmissions against queued host frames and
// launches one frame at a time toward the bit-level transmitter.
module can_tx_scheduler
    import can_tx_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int MAX_RETRIES    = 8,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    can_tx_scheduler_if.slave      host,
    input  logic                   retransmit_request,
    input  logic [10:0]            retransmit_identifier,
    input  logic [3:0]             retransmit_dlc,
    input  logic [63:0]            retransmit_data,
    input  logic                   retransmit_frame_type,
    input  logic [3:0]             retransmit_count,
    input  logic                   bus_idle,
    output logic                   tx_start,
    output logic [10:0]            tx_identifier,
    output logic [3:0]             tx_dlc,
    output logic [63:0]            tx_data,
    output logic                   tx_frame_type,
    input  logic                   tx_done,
    input  logic                   tx_error,
    output logic                   tx_source,
    output logic                   frame_aborted,
    output logic [$clog2(DEPTH):0] queue_count
);

    localparam int         HW    = $clog2(HOLDOFF_CYCLES + 2);
    localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

    sched_state_t  state_q;
    sched_state_t  state_d;
    can_frame_t    tx_q;
    can_frame_t    retx_frame;
    can_frame_t    host_frame;
    can_frame_t    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          launch_retx;
    logic          launch_fifo;
    logic          abort;
    logic          retx_served;
    logic [HW-1:0] holdoff_q;
    logic          retx_pending;
    logic          retx_elig;
    logic          abort_cond;
    logic          fifo_elig;
    logic          err_end;

    assign host_frame = {host.host_identifier, host.host_dlc,
                         host.host_data, host.host_frame_type};
    assign retx_frame = {retransmit_identifier, retransmit_dlc,
                         retransmit_data, retransmit_frame_type};

    assign host.host_ready = !fifo_full;

    tx_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (!enable),
        .push       (host.host_valid),
        .push_frame (host_frame),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (queue_count)
    );

    assign retx_pending = retransmit_request && !retx_served;
    assign retx_elig    = retx_pending && (retransmit_count <= MAX_R);
    assign abort_cond   = retx_pending && (retransmit_count > MAX_R);
    assign fifo_elig    = !fifo_empty && (holdoff_q == '0);
    assign err_end      = (state_q == ST_ACTIVE) && tx_error;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        launch_retx = 1'b0;
        launch_fifo = 1'b0;
        abort       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A dropped retransmit costs one idle cycle before FIFO traffic.
                if (abort_cond) begin
                    abort = 1'b1;
                end else if (bus_idle && retx_elig) begin
                    launch_retx = 1'b1;
                    state_d     = ST_LAUNCH;
                end else if (bus_idle && fifo_elig) begin
                    launch_fifo = 1'b1;
                    pop         = 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (tx_done || tx_error)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            tx_q          <= '0;
            tx_source     <= SRC_FIFO;
            frame_aborted <= 1'b0;
            retx_served   <= 1'b0;
            holdoff_q     <= '0;
        end else if (!enable) begin
            state_q       <= ST_IDLE;
            tx_q          <= '0;
            tx_source     <= SRC_FIFO;
            frame_aborted <= 1'b0;
            retx_served   <= 1'b0;
            holdoff_q     <= '0;
        end else begin
            state_q       <= state_d;
            frame_aborted <= abort;
            if (launch_retx) begin
                tx_q      <= retx_frame;
                tx_source <= SRC_RETX;
            end else if (launch_fifo) begin
                tx_q      <= fifo_head;
                tx_source <= SRC_FIFO;
            end
            // Lingering request level after completion must not relaunch.
            if (!retransmit_request)
                retx_served <= 1'b0;
            else if (launch_retx || abort)
                retx_served <= 1'b1;
            if (err_end)
                holdoff_q <= HW'(HOLDOFF_CYCLES);
            else if (holdoff_q != '0)
                holdoff_q <= holdoff_q - HW'(1);
        end
    end

    assign tx_start      = (state_q == ST_LAUNCH);
    assign tx_identifier = tx_q.id;
    assign tx_dlc        = tx_q.dlc;
    assign tx_data       = tx_q.data;
    assign tx_frame_type = tx_q.frame_type;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Scenario bench for can_tx_scheduler with a frame-queue
// reference model and randomized host/bus/completion traffic.
module tb_can_tx_scheduler;
    import can_tx_pkg::*;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int NRAND = 24;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        retransmit_request = 1'b0;
    logic [10:0] retransmit_identifier = '0;
    logic [3:0]  retransmit_dlc = '0;
    logic [63:0] retransmit_data = '0;
    logic        retransmit_frame_type = 1'b0;
    logic [3:0]  retransmit_count = '0;
    logic        bus_idle = 1'b0;
    logic        tx_start;
    logic [10:0] tx_identifier;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;
    logic        tx_frame_type;
    logic        tx_done = 1'b0;
    logic        tx_error = 1'b0;
    logic        tx_source;
    logic        frame_aborted;
    logic [2:0]  queue_count;

    int errors = 0;
    int checks = 0;
    can_frame_t exp_q[$];

    can_tx_scheduler_if hif();

    can_tx_scheduler #(
        .DEPTH(DEPTH), .MAX_RETRIES(8), .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .enable                (enable),
        .host                  (hif),
        .retransmit_request    (retransmit_request),
        .retransmit_identifier (retransmit_identifier),
        .retransmit_dlc        (retransmit_dlc),
        .retransmit_data       (retransmit_data),
        .retransmit_frame_type (retransmit_frame_type),
        .retransmit_count      (retransmit_count),
        .bus_idle              (bus_idle),
        .tx_start              (tx_start),
        .tx_identifier         (tx_identifier),
        .tx_dlc                (tx_dlc),
        .tx_data               (tx_data),
        .tx_frame_type         (tx_frame_type),
        .tx_done               (tx_done),
        .tx_error              (tx_error),
        .tx_source             (tx_source),
        .frame_aborted         (frame_aborted),
        .queue_count           (queue_count)
    );

    always #5 clock = ~clock;

    function automatic can_frame_t tx_now();
        return {tx_identifier, tx_dlc, tx_data, tx_frame_type};
    endfunction

    function automatic can_frame_t rand_frame();
        can_frame_t f;
        f.id         = 11'($urandom);
        f.dlc        = 4'($urandom_range(0, 8));
        f.data       = {$urandom, $urandom};
        f.frame_type = 1'($urandom_range(0, 1));
        return f;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_host(input can_frame_t f);
        hif.host_identifier = f.id;
        hif.host_dlc        = f.dlc;
        hif.host_data       = f.data;
        hif.host_frame_type = f.frame_type;
    endtask

    task automatic push_frame(input can_frame_t f);
        drive_host(f);
        hif.host_valid = 1'b1;
        step();
        hif.host_valid = 1'b0;
    endtask

    task automatic set_retx(input can_frame_t f, input logic [3:0] cnt);
        retransmit_identifier = f.id;
        retransmit_dlc        = f.dlc;
        retransmit_data       = f.data;
        retransmit_frame_type = f.frame_type;
        retransmit_count      = cnt;
        retransmit_request    = 1'b1;
    endtask

    task automatic wait_start(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (tx_start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic finish_frame();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        step();
        step();
        checks++;
        if (tx_start !== 1'b0 || frame_aborted !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: start=%b abort=%b want 0 0",
                     tx_start, frame_aborted);
        end
        checks++;
        if (queue_count !== 3'd0 || hif.host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: count=%0d ready=%b want 0 1",
                     queue_count, hif.host_ready);
        end
        checks++;
        if (tx_now() !== '0 || tx_source !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx: frame=%h src=%b want 0 0",
                     tx_now(), tx_source);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_latency();
        can_frame_t f;
        int n;
        f = '{id: 11'h123, dlc: 4'd8,
              data: 64'h1122334455667788, frame_type: 1'b0};
        bus_idle = 1'b1;
        push_frame(f);
        checks++;
        if (tx_start !== 1'b0 || queue_count !== 3'd1) begin
            errors++;
            $display("FAIL lat_push: start=%b count=%0d want 0 1",
                     tx_start, queue_count);
        end
        wait_start(8, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL lat_cycles: got %0d want 1", n);
        end
        checks++;
        if (tx_now() !== f || tx_source !== 1'b0) begin
            errors++;
            $display("FAIL lat_frame: got %h src %b want %h src 0",
                     tx_now(), tx_source, f);
        end
        step();
        checks++;
        if (tx_start !== 1'b0 || tx_now() !== f) begin
            errors++;
            $display("FAIL lat_hold: start=%b frame=%h want 0 %h",
                     tx_start, tx_now(), f);
        end
        finish_frame();
        step();
        checks++;
        if (tx_start !== 1'b0 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL lat_done: start=%b count=%0d want 0 0",
                     tx_start, queue_count);
        end
    endtask

    task automatic test_fill();
        can_frame_t f;
        int n;
        bus_idle = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            f = rand_frame();
            exp_q.push_back(f);
            push_frame(f);
        end
        checks++;
        if (hif.host_ready !== 1'b0 || queue_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: ready=%b count=%0d want 0 4",
                     hif.host_ready, queue_count);
        end
        push_frame(rand_frame());
        checks++;
        if (queue_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_drop: count=%0d want 4", queue_count);
        end
        bus_idle = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_start(10, n);
            f = exp_q.pop_front();
            checks++;
            if (n < 0 || tx_now() !== f || tx_source !== 1'b0) begin
                errors++;
                $display("FAIL fill_order%0d: got %h src %b want %h src 0",
                         i, tx_now(), tx_source, f);
            end
            step();
            finish_frame();
        end
        checks++;
        if (queue_count !== 3'd0) begin
            errors++;
            $display("FAIL fill_empty: count=%0d want 0", queue_count);
        end
    endtask

    task automatic test_retx_priority();
        can_frame_t f0, r;
        int n;
        bus_idle = 1'b0;
        f0 = rand_frame();
        f0.id = 11'h100;
        push_frame(f0);
        r = rand_frame();
        r.id = 11'h7FF;
        set_retx(r, 4'd2);
        bus_idle = 1'b1;
        wait_start(8, n);
        checks++;
        if (n < 0 || tx_now() !== r || tx_source !== 1'b1) begin
            errors++;
            $display("FAIL retx_first: got %h src %b want %h src 1",
                     tx_now(), tx_source, r);
        end
        step();
        finish_frame();
        wait_start(8, n);
        checks++;
        if (n < 0 || tx_now() !== f0 || tx_source !== 1'b0) begin
            errors++;
            $display("FAIL retx_then_fifo: got %h src %b want %h src 0",
                     tx_now(), tx_source, f0);
        end
        step();
        finish_frame();
        wait_start(6, n);
        checks++;
        if (n !== -1) begin
            errors++;
            $display("FAIL retx_relaunch: start after %0d want none", n);
        end
        retransmit_request = 1'b0;
        step();
    endtask

    task automatic test_holdoff();
        can_frame_t a, b;
        int n;
        bus_idle = 1'b0;
        a = rand_frame();
        b = rand_frame();
        push_frame(a);
        push_frame(b);
        bus_idle = 1'b1;
        wait_start(8, n);
        step();
        tx_error = 1'b1;
        step();
        tx_error = 1'b0;
        wait_start(20, n);
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL holdoff_gap: got %0d want %0d", n, HOLD + 1);
        end
        checks++;
        if (tx_now() !== b) begin
            errors++;
            $display("FAIL holdoff_frame: got %h want %h", tx_now(), b);
        end
        step();
        finish_frame();
    endtask

    task automatic test_abort();
        can_frame_t c;
        int starts, aborts, n;
        bus_idle = 1'b0;
        c = rand_frame();
        push_frame(c);
        set_retx(rand_frame(), 4'd9);
        bus_idle = 1'b1;
        step();
        checks++;
        if (frame_aborted !== 1'b1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: abort=%b start=%b want 1 0",
                     frame_aborted, tx_start);
        end
        step();
        checks++;
        if (frame_aborted !== 1'b0 || tx_start !== 1'b1 ||
            tx_now() !== c || tx_source !== 1'b0) begin
            errors++;
            $display("FAIL abort_next: abort=%b start=%b frame=%h want 0 1 %h",
                     frame_aborted, tx_start, tx_now(), c);
        end
        step();
        finish_frame();
        starts = 0;
        aborts = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            starts += int'(tx_start);
            aborts += int'(frame_aborted);
        end
        checks++;
        if (starts != 0 || aborts != 0) begin
            errors++;
            $display("FAIL abort_quiet: starts=%0d aborts=%0d want 0 0",
                     starts, aborts);
        end
        retransmit_request = 1'b0;
        wait_start(2, n);
    endtask

    task automatic test_flush();
        can_frame_t d, h, r;
        int n;
        bus_idle = 1'b0;
        d = rand_frame();
        push_frame(d);
        push_frame(rand_frame());
        bus_idle = 1'b1;
        wait_start(8, n);
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx_now() !== '0 || queue_count !== 3'd0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL flush_reset: frame=%h count=%0d start=%b want 0",
                     tx_now(), queue_count, tx_start);
        end
        step();
        reset_n = 1'b1;
        step();
        finish_frame();
        wait_start(6, n);
        checks++;
        if (n !== -1) begin
            errors++;
            $display("FAIL flush_reset_done: start after %0d want none", n);
        end
        bus_idle = 1'b0;
        h = rand_frame();
        push_frame(h);
        r = rand_frame();
        set_retx(r, 4'd3);
        bus_idle = 1'b1;
        wait_start(8, n);
        checks++;
        if (n < 0 || tx_source !== 1'b1 || tx_now() !== r) begin
            errors++;
            $display("FAIL flush_pre: src=%b frame=%h want 1 %h",
                     tx_source, tx_now(), r);
        end
        step();
        enable = 1'b0;
        retransmit_request = 1'b0;
        step();
        checks++;
        if (tx_now() !== '0 || tx_source !== 1'b0 ||
            queue_count !== 3'd0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL flush_enable: frame=%h src=%b count=%0d want 0",
                     tx_now(), tx_source, queue_count);
        end
        enable = 1'b1;
        finish_frame();
        wait_start(6, n);
        checks++;
        if (n !== -1) begin
            errors++;
            $display("FAIL flush_enable_done: start after %0d want none", n);
        end
    endtask

    task automatic test_done_and_error();
        can_frame_t p, q;
        int n;
        bus_idle = 1'b0;
        p = rand_frame();
        q = rand_frame();
        push_frame(p);
        push_frame(q);
        bus_idle = 1'b1;
        wait_start(8, n);
        step();
        tx_done  = 1'b1;
        tx_error = 1'b1;
        step();
        tx_done  = 1'b0;
        tx_error = 1'b0;
        wait_start(20, n);
        checks++;
        if (n !== HOLD + 1 || tx_now() !== q) begin
            errors++;
            $display("FAIL both_holdoff: gap=%0d frame=%h want %0d %h",
                     n, tx_now(), HOLD + 1, q);
        end
        step();
        finish_frame();
    endtask

    task automatic test_random();
        can_frame_t cur, f;
        int sent, got, dly;
        bit active, acc;
        sent   = 0;
        got    = 0;
        dly    = 0;
        active = 1'b0;
        cur    = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 4000 && got < NRAND; cyc++) begin
            if (!hif.host_valid && sent < NRAND &&
                $urandom_range(0, 2) == 0) begin
                cur = rand_frame();
                drive_host(cur);
                hif.host_valid = 1'b1;
            end
            bus_idle = ($urandom_range(0, 3) != 0);
            if (active) begin
                if (dly == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        tx_error = 1'b1;
                    else
                        tx_done = 1'b1;
                    active = 1'b0;
                end else begin
                    dly--;
                end
            end
            acc = hif.host_valid && hif.host_ready;
            step();
            tx_done  = 1'b0;
            tx_error = 1'b0;
            if (acc) begin
                exp_q.push_back(cur);
                sent++;
                hif.host_valid = 1'b0;
            end
            if (tx_start) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious: frame=%h with empty model",
                             tx_now());
                end else begin
                    f = exp_q.pop_front();
                    if (tx_now() !== f || tx_source !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_frame%0d: got %h src %b want %h",
                                 got, tx_now(), tx_source, f);
                    end
                end
                got++;
                active = 1'b1;
                dly = $urandom_range(1, 4);
            end
        end
        hif.host_valid = 1'b0;
        checks++;
        if (got != NRAND || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_total: launched=%0d left=%0d want %0d 0",
                     got, exp_q.size(), NRAND);
        end
    endtask

    initial begin
        hif.host_valid      = 1'b0;
        hif.host_identifier = '0;
        hif.host_dlc        = '0;
        hif.host_data       = '0;
        hif.host_frame_type = 1'b0;
        test_reset();
        test_latency();
        test_fill();
        test_retx_priority();
        test_holdoff();
        test_abort();
        test_flush();
        test_done_and_error();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
